imem_loader: RTL and testbench

- Writer-side companion to the instruction memory, which the CPU datapath only ever reads (PC-indexed, 32 words).
- Accepts a byte stream over a valid/ready handshake and packs bytes big-endian into 32-bit instruction words.
- Writes each word to consecutive instruction-memory addresses starting at 0.
- Holds the CPU (PC/register-write stall) for the whole load, then pulses done.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_byte_packer.sv | 39 +++
 rtl/imem_loader.sv | 130 +++++++++++++
 tb/tb_imem_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W    = 5;
  localparam int IMEM_WORD_W    = 32;
  localparam int BYTES_PER_WORD = IMEM_WORD_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHECK,
    ST_DONE
  } state_t;

  // A length byte of zero requests a full memory image.
  function automatic logic [8:0] words_to_load(input logic [7:0] n, input logic [8:0] depth);
    return (n == 8'd0) ? depth : {1'b0, n};
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: the first byte of a word ends up in the top byte lane.
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int WORD_W = IMEM_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        in_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              last_byte
);

  localparam int BPW   = WORD_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CNT_W-1:0] byte_cnt;

  assign last_byte = (byte_cnt == CNT_W'(BPW - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word       <= '0;
      byte_cnt   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= shift_en && last_byte;
      if (shift_en) begin
        word     <= WORD_W'({word, in_data});
        byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory while holding the CPU.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int WORD_W = IMEM_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  // Length arithmetic is 9 bits wide, enough for memories up to 256 words.
  localparam logic [8:0] DEPTH = 9'(2 ** ADDR_W);

  state_t            state, state_d;
  logic              accept, start_ok, pack_en, last_byte, word_valid, final_byte;
  logic [8:0]        n_words, rem_words;
  logic [ADDR_W-1:0] word_cnt;
  logic [WORD_W-1:0] packed_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept     = in_valid && in_ready;
  assign start_ok   = start && (state == ST_IDLE);
  assign pack_en    = accept && (state == ST_DATA);
  assign n_words    = words_to_load(in_data, DEPTH);
  assign final_byte = pack_en && last_byte && (rem_words == 9'd1);

  assign wr_en   = word_valid;
  assign wr_addr = word_cnt;
  assign wr_data = packed_word;

  byte_packer #(.WORD_W(WORD_W)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .shift_en  (pack_en),
    .in_data   (in_data),
    .word      (packed_word),
    .word_valid(word_valid),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: if (start) state_d = ST_LEN;
      ST_LEN: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (accept) state_d = (n_words > DEPTH) ? ST_DONE : ST_DATA;
      end
      ST_DATA: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (final_byte) state_d = ST_CHECK;
`else
        if (final_byte) state_d = ST_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (accept) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The address counter advances on the write itself, so a byte may be accepted alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err       <= 1'b0;
      word_cnt  <= '0;
      rem_words <= '0;
    end else begin
      if (word_valid) word_cnt <= word_cnt + 1'b1;
      if (pack_en && last_byte) rem_words <= rem_words - 1'b1;
      if (state == ST_LEN && accept) begin
        if (n_words > DEPTH) err <= 1'b1;
        else                 rem_words <= n_words;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == ST_CHECK && accept && in_data != csum) err <= 1'b1;
`endif
      if (start_ok) begin
        err       <= 1'b0;
        word_cnt  <= '0;
        rem_words <= '0;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)          csum <= 8'h00;
    else if (start_ok) csum <= 8'h00;
    else if (pack_en)  csum <= csum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; outputs are sampled 1 time unit after each rising edge.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, wr_en, cpu_hold, done, err;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [36:0] wlog[$];
  logic [7:0]  cs_byte = 8'hAC;

  imem_loader dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cpu_hold(cpu_hold),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) wlog.push_back({wr_addr, wr_data});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Two-word program; optional idle cycles between bytes must not lose or repeat data.
  task automatic load_body(input string tag, input bit gaps);
    logic [7:0] b [9] = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    wlog.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ":hold_len"}, cpu_hold, 1);
    chk({tag, ":ready_len"}, in_ready, 1);
    for (int i = 0; i < 9; i++) begin
      send(b[i]);
      if (i == 4) begin
        chk({tag, ":w0_en"}, wr_en, 1);
        chk({tag, ":w0_addr"}, wr_addr, 0);
        chk({tag, ":w0_data"}, wr_data, 32'h20080005);
      end else if (i == 8) begin
        chk({tag, ":w1_en"}, wr_en, 1);
        chk({tag, ":w1_addr"}, wr_addr, 1);
        chk({tag, ":w1_data"}, wr_data, 32'h8C090004);
      end else if (i == 5) begin
        chk({tag, ":no_dup"}, wr_en, 0);
        chk({tag, ":addr_inc"}, wr_addr, 1);
      end
      if (gaps && i != 8) begin
        in_data = 8'hFF;
        step();
        chk({tag, ":gap_no_wr"}, wr_en, 0);
      end
    end
  endtask

  task automatic end_load(input string tag, input logic exp_err);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk({tag, ":chk_no_done"}, done, 0);
    chk({tag, ":chk_hold"}, cpu_hold, 1);
    chk({tag, ":chk_ready"}, in_ready, 1);
    send(cs_byte);
`endif
    chk({tag, ":done"}, done, 1);
    chk({tag, ":hold_off"}, cpu_hold, 0);
    chk({tag, ":err"}, err, exp_err);
    chk({tag, ":ready_done"}, in_ready, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ":done_pulse"}, done, 0);
    chk({tag, ":start_in_done_ignored"}, in_ready, 0);
    chk({tag, ":err_sticky"}, err, exp_err);
    step();
  endtask

  task automatic check_two_words(input string tag);
    chk({tag, ":nwrites"}, wlog.size(), 2);
    chk({tag, ":log0"}, wlog[0], {5'd0, 32'h20080005});
    chk({tag, ":log1"}, wlog[1], {5'd1, 32'h8C090004});
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst:in_ready", in_ready, 0);
    chk("rst:wr_en", wr_en, 0);
    chk("rst:cpu_hold", cpu_hold, 0);
    chk("rst:done", done, 0);
    chk("rst:err", err, 0);
    chk("rst:wr_addr", wr_addr, 0);
    chk("rst:wr_data", wr_data, 0);
    rst = 1'b0;
    step();

    // Basic load
    load_body("basic", 1'b0);
    end_load("basic", 1'b0);
    check_two_words("basic");

    // Oversize length: 33 words cannot fit
    wlog.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    send(8'h21);
    chk("over:done", done, 1);
    chk("over:err", err, 1);
    chk("over:hold_off", cpu_hold, 0);
    chk("over:wr_en", wr_en, 0);
    step();
    chk("over:err_sticky", err, 1);
    chk("over:done_pulse", done, 0);
    chk("over:nwrites", wlog.size(), 0);

    // Next start clears err; then reset in the middle of a word
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rstmid:err_clear", err, 0);
    chk("rstmid:hold", cpu_hold, 1);
    send(8'h01);
    send(8'hAA);
    send(8'hBB);
    chk("rstmid:no_wr_before", wr_en, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid:wr_en", wr_en, 0);
    chk("rstmid:hold_off", cpu_hold, 0);
    chk("rstmid:idle", in_ready, 0);
    chk("rstmid:wr_data", wr_data, 0);
    step();
    step();
    chk("rstmid:nwrites", wlog.size(), 0);

    // Clean load after the aborted one
    load_body("clean", 1'b0);
    end_load("clean", 1'b0);
    check_two_words("clean");

    // Same stream with in_valid toggling
    load_body("gaps", 1'b1);
    end_load("gaps", 1'b0);
    check_two_words("gaps");

    // Full memory: N=0 means 32 words, byte i = i; XOR of 0..127 is zero
    wlog.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    send(8'h00);
    for (int i = 0; i < 128; i++) send(8'(i));
    chk("full:last_en", wr_en, 1);
    chk("full:last_addr", wr_addr, 31);
    cs_byte = 8'h00;
    end_load("full", 1'b0);
    step();
    step();
    chk("full:nwrites", wlog.size(), 32);
    chk("full:log0", wlog[0], {5'd0, 32'h00010203});
    chk("full:log16", wlog[16], {5'd16, 32'h40414243});
    chk("full:log31", wlog[31], {5'd31, 32'h7C7D7E7F});

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum byte: error flagged, words still written
    cs_byte = 8'h00;
    load_body("badcs", 1'b0);
    end_load("badcs", 1'b1);
    check_two_words("badcs");
    // Correct checksum (XOR of the eight data bytes) after an error clears it
    cs_byte = 8'hAC;
    load_body("goodcs", 1'b0);
    end_load("goodcs", 1'b0);
    check_two_words("goodcs");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
